rrq_wrr: RTL and testbench

Parametrised successor to the round-robin read-queue arbiter. Selects which application's data queue is read next and issues a single-cycle read request, then waits for the read to complete. Adds per-app enable masking, per-app weights (burst credits of consecutive reads), and a busy indication. Sits between the per-app data queues and the shared read/transfer engine.

---
 rtl/rrq_pkg.sv | 34 +++
 rtl/rr_prio_enc.sv | 33 +++
 rtl/rrq_wrr.sv | 136 +++++++++++++
 tb/tb_rrq_wrr.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rrq_pkg.sv
// Shared types and helpers for the weighted round-robin read-queue arbiter.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: not applicable.
package rrq_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam int DEF_TOTAL_APPS     = 8;
    localparam int DEF_WEIGHT_WIDTH   = 4;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    // Upper bounds for the weight-extract helper; the top checks its parameters against them.
    localparam int MAX_WEIGHT_VEC   = 1024;
    localparam int MAX_WEIGHT_WIDTH = 16;

    function automatic logic [MAX_WEIGHT_WIDTH-1:0] weight_field(
        input logic [MAX_WEIGHT_VEC-1:0] vec,
        input int                        idx,
        input int                        width
    );
        logic [MAX_WEIGHT_WIDTH-1:0] r;
        r = '0;
        for (int b = 0; b < MAX_WEIGHT_WIDTH; b++) begin
            if (b < width && (idx * width + b) < MAX_WEIGHT_VEC) begin
                r[b] = vec[idx * width + b];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Rotating-priority encoder: first set req bit scanning from ptr upwards, wrapping at N.
// Latency: purely combinational.
// Backpressure: none; valid low when no request is set.
module rr_prio_enc #(
    parameter int N = 8,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] index
);

    int j;

    // Scan from the far end down so the candidate closest to ptr is written last and wins.
    always_comb begin
        valid = 1'b0;
        index = '0;
        j     = 0;
        for (int i = N - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (req[j]) begin
                valid = 1'b1;
                index = W'(j);
            end
        end
    end

endmodule

// File: rtl/rrq_wrr.sv
// Weighted round-robin read-queue arbiter with per-app enable; optional watchdog under RRQ_TIMEOUT_EN.
// Latency: eligible -> read_queue 1 cycle; read_done -> burst continuation 1 cycle, next app 2 cycles.
// Backpressure: one read outstanding at a time; busy holds off new grants until read_done (or timeout).
module rrq_wrr
    import rrq_pkg::*;
#(
    parameter int TOTAL_APPS     = DEF_TOTAL_APPS,
    parameter int APP_ID_WIDTH   = (TOTAL_APPS > 1) ? $clog2(TOTAL_APPS) : 1,
    parameter int WEIGHT_WIDTH   = DEF_WEIGHT_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [TOTAL_APPS-1:0]                data_queue_empty,
    input  logic [TOTAL_APPS-1:0]                app_enable,
    input  logic [TOTAL_APPS*WEIGHT_WIDTH-1:0]   app_weight,
    input  logic                                 read_done,
    output logic                                 read_queue,
    output logic [APP_ID_WIDTH-1:0]              app_id,
    output logic                                 busy,
    output logic                                 timeout
);

    if (TOTAL_APPS < 1 || TIMEOUT_CYCLES < 1 || WEIGHT_WIDTH > MAX_WEIGHT_WIDTH ||
        TOTAL_APPS * WEIGHT_WIDTH > MAX_WEIGHT_VEC) begin : g_bad_params
        $error("rrq_wrr: unsupported parameter set");
    end

    localparam logic [APP_ID_WIDTH-1:0] LAST_APP = APP_ID_WIDTH'(TOTAL_APPS - 1);

    state_t                    state;
    logic [APP_ID_WIDTH-1:0]   ptr;
    logic [APP_ID_WIDTH-1:0]   sel_idx;
    logic                      sel_vld;
    logic [APP_ID_WIDTH-1:0]   next_ptr;
    logic [TOTAL_APPS-1:0]     eligible;
    logic [WEIGHT_WIDTH-1:0]   credit;
    logic [WEIGHT_WIDTH-1:0]   credit_dec;
    logic [WEIGHT_WIDTH-1:0]   sel_weight;
    logic [WEIGHT_WIDTH-1:0]   grant_credit;
    logic [MAX_WEIGHT_VEC-1:0] weight_vec;
    logic                      burst_cont;

    assign eligible     = ~data_queue_empty & app_enable;
    assign weight_vec   = MAX_WEIGHT_VEC'(app_weight);
    assign sel_weight   = WEIGHT_WIDTH'(weight_field(weight_vec, int'(sel_idx), WEIGHT_WIDTH));
    // A zero weight still earns the app one read per turn.
    assign grant_credit = (sel_weight == '0) ? WEIGHT_WIDTH'(1) : sel_weight;
    assign credit_dec   = credit - WEIGHT_WIDTH'(1);
    assign burst_cont   = (credit_dec != '0) && eligible[app_id];
    assign next_ptr     = (app_id == LAST_APP) ? '0 : app_id + APP_ID_WIDTH'(1);

    rr_prio_enc #(
        .N (TOTAL_APPS),
        .W (APP_ID_WIDTH)
    ) u_prio_enc (
        .req   (eligible),
        .ptr   (ptr),
        .valid (sel_vld),
        .index (sel_idx)
    );

`ifdef RRQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             expire;

    // The cycle that would bring the count to the limit raises timeout on the next edge.
    assign expire = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            credit     <= '0;
            app_id     <= '0;
            read_queue <= 1'b0;
            busy       <= 1'b0;
`ifdef RRQ_TIMEOUT_EN
            wait_cnt   <= '0;
            timeout    <= 1'b0;
`endif
        end else begin
            read_queue <= 1'b0;
`ifdef RRQ_TIMEOUT_EN
            timeout    <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (sel_vld) begin
                        read_queue <= 1'b1;
                        app_id     <= sel_idx;
                        busy       <= 1'b1;
                        credit     <= grant_credit;
                        state      <= ST_WAIT;
`ifdef RRQ_TIMEOUT_EN
                        wait_cnt   <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (read_done) begin
                        credit <= credit_dec;
                        if (burst_cont) begin
                            read_queue <= 1'b1;
`ifdef RRQ_TIMEOUT_EN
                            wait_cnt   <= '0;
`endif
                        end else begin
                            ptr   <= next_ptr;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
`ifdef RRQ_TIMEOUT_EN
                    else if (expire) begin
                        timeout <= 1'b1;
                        credit  <= '0;
                        ptr     <= next_ptr;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rrq_wrr.sv
// Directed bench for rrq_wrr: round-robin order, weighted bursts, wrap, enable drop, watchdog, reset.
module tb_rrq_wrr;

    localparam int N  = 8;
    localparam int AW = 3;
    localparam int WW = 4;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    data_queue_empty;
    logic [N-1:0]    app_enable;
    logic [N*WW-1:0] app_weight;
    logic            read_done;
    logic            read_queue;
    logic [AW-1:0]   app_id;
    logic            busy;
    logic            timeout;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    rrq_wrr #(
        .TOTAL_APPS     (N),
        .APP_ID_WIDTH   (AW),
        .WEIGHT_WIDTH   (WW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .data_queue_empty (data_queue_empty),
        .app_enable       (app_enable),
        .app_weight       (app_weight),
        .read_done        (read_done),
        .read_queue       (read_queue),
        .app_id           (app_id),
        .busy             (busy),
        .timeout          (timeout)
    );

    task automatic set_weight(input int app, input int w);
        app_weight[app*WW +: WW] = WW'(w);
    endtask

    // Returns how many negedges passed (0 = already high now) before read_queue was seen.
    task automatic wait_rq(input int max, output int n, output bit ok);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i <= max; i++) begin
            if (read_queue === 1'b1) begin
                ok = 1'b1;
                n  = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic pulse_done;
        read_done = 1'b1;
        @(negedge clk);
        read_done = 1'b0;
    endtask

    task automatic test_reset;
        rst_n            = 1'b0;
        read_done        = 1'b0;
        data_queue_empty = '1;
        app_enable       = '1;
        for (int a = 0; a < N; a++) set_weight(a, 1);
        repeat (3) @(negedge clk);
        tests_run++;
        if ({read_queue, busy, timeout, app_id} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got rq=%b busy=%b to=%b id=%0d, expected all 0",
                     read_queue, busy, timeout, app_id);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            tests_run++;
            if (read_queue !== 1'b0 || busy !== 1'b0 || app_id !== '0) begin
                tests_failed++;
                $display("FAIL idle_empty cycle %0d: got rq=%b busy=%b id=%0d, expected 0/0/0",
                         c, read_queue, busy, app_id);
            end
        end
        pulse_done;
        for (int c = 0; c < 5; c++) begin
            tests_run++;
            if (read_queue !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL done_in_idle cycle %0d: got rq=%b busy=%b, expected 0/0",
                         c, read_queue, busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_rr_order;
        int n;
        bit ok;
        int exp_seq[4] = '{1, 5, 1, 5};
        data_queue_empty = ~8'b0010_0010;
        for (int k = 0; k < 4; k++) begin
            wait_rq(8, n, ok);
            tests_run++;
            if (!ok || app_id !== AW'(exp_seq[k])) begin
                tests_failed++;
                $display("FAIL rr_grant %0d: got ok=%b id=%0d, expected id=%0d", k, ok, app_id, exp_seq[k]);
            end
            tests_run++;
            if (n != 1) begin
                tests_failed++;
                $display("FAIL rr_latency %0d: got %0d cycles, expected 1", k, n);
            end
            @(negedge clk);
            tests_run++;
            if (read_queue !== 1'b0 || busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL rr_pulse %0d: got rq=%b busy=%b, expected 0/1", k, read_queue, busy);
            end
            repeat (2) @(negedge clk);
            if (k == 3) data_queue_empty = '1;
            pulse_done;
            tests_run++;
            if (busy !== 1'b0 || read_queue !== 1'b0) begin
                tests_failed++;
                $display("FAIL rr_release %0d: got busy=%b rq=%b, expected 0/0", k, busy, read_queue);
            end
        end
    endtask

    task automatic test_weight_burst;
        int n;
        bit ok;
        set_weight(2, 3);
        data_queue_empty = ~8'b0000_0100;
        wait_rq(8, n, ok);
        tests_run++;
        if (!ok || app_id !== AW'(2) || n != 1) begin
            tests_failed++;
            $display("FAIL burst_first: got ok=%b id=%0d n=%0d, expected id=2 n=1", ok, app_id, n);
        end
        data_queue_empty = ~8'b0100_0100;
        for (int b = 0; b < 3; b++) begin
            if (b == 1) repeat (2) @(negedge clk);
            pulse_done;
            tests_run++;
            if (b < 2) begin
                if (read_queue !== 1'b1 || app_id !== AW'(2) || busy !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL burst_cont %0d: got rq=%b id=%0d busy=%b, expected 1/2/1",
                             b, read_queue, app_id, busy);
                end
            end else if (read_queue !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL burst_end: got rq=%b busy=%b, expected 0/0", read_queue, busy);
            end
        end
        wait_rq(8, n, ok);
        tests_run++;
        if (!ok || app_id !== AW'(6) || n != 1) begin
            tests_failed++;
            $display("FAIL burst_next: got ok=%b id=%0d n=%0d, expected id=6 n=1", ok, app_id, n);
        end
        data_queue_empty = '1;
        pulse_done;
        set_weight(2, 1);
    endtask

    task automatic test_wrap;
        int n;
        bit ok;
        set_weight(7, 0);
        data_queue_empty = ~8'b1000_0001;
        wait_rq(8, n, ok);
        tests_run++;
        if (!ok || app_id !== AW'(7)) begin
            tests_failed++;
            $display("FAIL wrap_first: got ok=%b id=%0d, expected id=7", ok, app_id);
        end
        pulse_done;
        tests_run++;
        if (read_queue !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL weight0_single: got rq=%b busy=%b, expected 0/0", read_queue, busy);
        end
        wait_rq(8, n, ok);
        tests_run++;
        if (!ok || app_id !== AW'(0) || n != 1) begin
            tests_failed++;
            $display("FAIL wrap_next: got ok=%b id=%0d n=%0d, expected id=0 n=1", ok, app_id, n);
        end
        data_queue_empty = '1;
        pulse_done;
        set_weight(7, 1);
    endtask

    task automatic test_enable_drop;
        int n;
        bit ok;
        set_weight(3, 4);
        data_queue_empty = ~8'b0100_1000;
        wait_rq(8, n, ok);
        tests_run++;
        if (!ok || app_id !== AW'(3)) begin
            tests_failed++;
            $display("FAIL drop_first: got ok=%b id=%0d, expected id=3", ok, app_id);
        end
        @(negedge clk);
        app_enable[3] = 1'b0;
        @(negedge clk);
        pulse_done;
        tests_run++;
        if (read_queue !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL drop_no_cont: got rq=%b busy=%b, expected 0/0", read_queue, busy);
        end
        wait_rq(8, n, ok);
        tests_run++;
        if (!ok || app_id !== AW'(6) || n != 1) begin
            tests_failed++;
            $display("FAIL drop_next: got ok=%b id=%0d n=%0d, expected id=6 n=1", ok, app_id, n);
        end
        data_queue_empty = '1;
        app_enable       = '1;
        pulse_done;
        set_weight(3, 1);
    endtask

`ifdef RRQ_TIMEOUT_EN
    task automatic test_timeout;
        int n;
        bit ok;
        bit early;
        data_queue_empty = ~8'b0000_0110;
        wait_rq(8, n, ok);
        tests_run++;
        if (!ok || app_id !== AW'(1)) begin
            tests_failed++;
            $display("FAIL to_first: got ok=%b id=%0d, expected id=1", ok, app_id);
        end
        early = 1'b0;
        for (int k = 1; k < TO; k++) begin
            @(negedge clk);
            if (timeout !== 1'b0) early = 1'b1;
        end
        tests_run++;
        if (early) begin
            tests_failed++;
            $display("FAIL to_early: got timeout before cycle %0d, expected none", TO);
        end
        @(negedge clk);
        tests_run++;
        if (timeout !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL to_pulse: got to=%b busy=%b, expected 1/0", timeout, busy);
        end
        @(negedge clk);
        tests_run++;
        if (read_queue !== 1'b1 || app_id !== AW'(2) || timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL to_next: got rq=%b id=%0d to=%b, expected 1/2/0", read_queue, app_id, timeout);
        end
        repeat (TO - 1) @(negedge clk);
        data_queue_empty = '1;
        pulse_done;
        early = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (timeout !== 1'b0 || busy !== 1'b0 || read_queue !== 1'b0) early = 1'b1;
            @(negedge clk);
        end
        tests_run++;
        if (early) begin
            tests_failed++;
            $display("FAIL to_done_wins: got timeout/busy/rq activity, expected quiet idle");
        end
    endtask
`else
    task automatic test_no_timeout;
        int n;
        bit ok;
        bit bad;
        data_queue_empty = ~8'b0000_1000;
        wait_rq(8, n, ok);
        tests_run++;
        if (!ok || app_id !== AW'(3)) begin
            tests_failed++;
            $display("FAIL hold_first: got ok=%b id=%0d, expected id=3", ok, app_id);
        end
        bad = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (timeout !== 1'b0 || busy !== 1'b1 || read_queue !== 1'b0) bad = 1'b1;
        end
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("FAIL hold_wait: got timeout or early release, expected busy held 40 cycles");
        end
        data_queue_empty = '1;
        pulse_done;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_release: got busy=%b, expected 0", busy);
        end
    endtask
`endif

    task automatic test_reset_mid_read;
        int n;
        bit ok;
        data_queue_empty = ~8'b0010_0000;
        wait_rq(8, n, ok);
        tests_run++;
        if (!ok || app_id !== AW'(5)) begin
            tests_failed++;
            $display("FAIL mid_first: got ok=%b id=%0d, expected id=5", ok, app_id);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({read_queue, busy, timeout, app_id} !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset: got rq=%b busy=%b to=%b id=%0d, expected all 0",
                     read_queue, busy, timeout, app_id);
        end
        repeat (2) @(negedge clk);
        rst_n            = 1'b1;
        data_queue_empty = ~8'b1000_0001;
        wait_rq(8, n, ok);
        tests_run++;
        if (!ok || app_id !== AW'(0) || n != 1) begin
            tests_failed++;
            $display("FAIL mid_regrant: got ok=%b id=%0d n=%0d, expected id=0 n=1", ok, app_id, n);
        end
        data_queue_empty = '1;
        pulse_done;
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_release: got busy=%b, expected 0", busy);
        end
    endtask

    initial begin
        test_reset;
        test_rr_order;
        test_weight_burst;
        test_wrap;
        test_enable_drop;
`ifdef RRQ_TIMEOUT_EN
        test_timeout;
`else
        test_no_timeout;
`endif
        test_reset_mid_read;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
